prefetch_q: RTL

Parametrised instruction prefetch queue between the instruction memory port and the `if_id` pipeline register, replacing the single-byte, no-buffer fetch path. It issues sequential reads of `BUS_BYTES` per beat, assembles little-endian 32-bit instructions, and buffers up to `DEPTH` of them with their PCs. It presents them to decode through a valid/ready handshake, and supports pipeline redirect (flush) and memory-port arbitration stalls.

---
 rtl/prefetch_q.sv | 135 +++++++++++++
 1 files changed

// File: rtl/prefetch_q.sv
// Instruction prefetch queue: issues sequential memory beats, assembles 32-bit
// little-endian instructions and buffers them with their PCs for decode.
module prefetch_q #(
    parameter int unsigned BUS_BYTES = 1,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            mem_a,
    output logic                   mem_rd,
    input  logic                   mem_gnt,
    input  logic [8*BUS_BYTES-1:0] mem_rn,
    input  logic                   redir,
    input  logic [31:0]            redir_pc,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [31:0]            is_o,
    output logic [31:0]            pc_o
);

    localparam int unsigned BEATS = 4 / BUS_BYTES;
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [BCW-1:0] LAST_BC = BCW'(BEATS - 1);

    logic [31:0]    fpc;
    logic [BCW-1:0] bc;
    logic [BCW-1:0] ret_bc;
    logic           busy;
    logic           pend;
    logic           kill;
    logic           hold;
    logic [31:0]    asm_w;
    logic [31:0]    asm_pc;
    logic [31:0]    asm_nxt;
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  cnt;
    logic [CW:0]    used;
    logic [31:0]    q_is [DEPTH];
    logic [31:0]    q_pc [DEPTH];

    logic pop;
    logic push;
    logic wr;
    logic acc;
    logic room;
    logic unused_pc_bits;

    assign unused_pc_bits = ^redir_pc[1:0];

    // Head presentation is driven from stored state only, never from ready_i.
    assign valid_o = (cnt != '0);
    assign is_o    = valid_o ? q_is[head] : NOP;
    assign pc_o    = valid_o ? q_pc[head] : 32'h0;
    assign pop     = valid_o & ready_i;

    // A first beat needs a free slot counting the instruction still assembling;
    // hold keeps a stalled request up even if the slot check would now fail.
    assign used   = (CW+1)'(cnt) + (CW+1)'(busy) - (CW+1)'(pop);
    assign room   = (used < (CW+1)'(DEPTH));
    assign mem_rd = !rst && !redir && (hold || (bc != '0) || room);
    assign mem_a  = fpc + 32'(bc) * BUS_BYTES;
    assign acc    = mem_rd & mem_gnt;

    assign wr   = pend & !kill & !redir;
    assign push = wr & (ret_bc == LAST_BC);

    // Merge the returning beat into its byte lanes of the assembly word.
    always_comb begin
        asm_nxt = asm_w;
        for (int i = 0; i < int'(BUS_BYTES); i++) begin
            asm_nxt[8*(int'(ret_bc)*int'(BUS_BYTES) + i) +: 8] = mem_rn[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc    <= RESET_PC;
            bc     <= '0;
            ret_bc <= '0;
            busy   <= 1'b0;
            pend   <= 1'b0;
            kill   <= 1'b0;
            hold   <= 1'b0;
            asm_w  <= '0;
            asm_pc <= '0;
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
        end else if (redir) begin
            fpc  <= {redir_pc[31:2], 2'b00};
            bc   <= '0;
            busy <= 1'b0;
            pend <= 1'b0;
            kill <= pend;
            hold <= 1'b0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            pend <= acc;
            kill <= 1'b0;
            hold <= mem_rd & !mem_gnt;
            if (acc) begin
                ret_bc <= bc;
                if (bc == '0) asm_pc <= fpc;
                if (bc == LAST_BC) begin
                    bc  <= '0;
                    fpc <= fpc + 32'd4;
                end else begin
                    bc <= bc + BCW'(1);
                end
            end
            if (wr) asm_w <= asm_nxt;
            if (acc && (bc == '0)) busy <= 1'b1;
            else if (push)         busy <= 1'b0;
            if (pop)  head <= head + PW'(1);
            if (push) tail <= tail + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Slot storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            q_is[tail] <= asm_nxt;
            q_pc[tail] <= asm_pc;
        end
    end

endmodule
